// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the bus decoders.
//   wb_slv_e        : slave index (WB_SLV_A = memory, WB_SLV_B = peripherals)
//   wb_adr_t        : default-width bus address
//   WB_B_BASE/MASK  : default decode window for slave B
package wb_pkg;

  localparam int unsigned WB_AW = 19;

  typedef enum logic {
    WB_SLV_A = 1'b0,
    WB_SLV_B = 1'b1
  } wb_slv_e;

  typedef logic [WB_AW-1:0] wb_adr_t;

  localparam wb_adr_t WB_B_BASE = 19'h10000;
  localparam wb_adr_t WB_B_MASK = 19'h70000;

endpackage

// File: rtl/wb_pipecount.sv
// Outstanding-request counter for pipelined Wishbone routing.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_inc        : a request was accepted this cycle
//   i_dec        : an acknowledgement retired a request this cycle
//   i_clr        : drop all outstanding requests (overrides inc/dec)
//   o_cnt        : current outstanding count
//   o_full       : count at its maximum, no further requests may issue
//   o_empty      : nothing outstanding
module wb_pipecount #(
  parameter int unsigned LGPIPE = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_inc,
  input  logic              i_dec,
  input  logic              i_clr,
  output logic [LGPIPE-1:0] o_cnt,
  output logic              o_full,
  output logic              o_empty
);

  logic [LGPIPE-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !i_dec) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (i_dec && !i_inc) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt   = r_cnt;
  assign o_full  = (r_cnt == '1);
  assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/wb_splitter.sv
// Single-master to two-slave pipelined Wishbone address decoder/router.
// Requests are routed by address (slave B when (adr & B_MASK) == B_BASE,
// else slave A); ack/err/data return from the slave owning the outstanding
// requests. Switching slaves stalls until every outstanding request is acked.
// An error aborts the bus cycle until the master drops i_cyc.
//   i_clk, i_rst                 : clock, asynchronous active-high reset
//   i_cyc/i_stb/i_we/i_adr/i_dat : master request
//   o_ack/o_stall/o_err/o_data   : master response
//   o_a_* / i_a_*                : slave A (memory) port
//   o_b_* / i_b_*                : slave B (peripherals) port
// Optional: define WBS_TIMEOUT_EN to add an ack timeout of TIMEOUT cycles
// that raises o_err like a slave error.
module wb_splitter
  import wb_pkg::*;
#(
  parameter int unsigned    AW      = 19,
  parameter int unsigned    DW      = 32,
  parameter logic [AW-1:0]  B_BASE  = AW'(WB_B_BASE),
  parameter logic [AW-1:0]  B_MASK  = AW'(WB_B_MASK),
  parameter int unsigned    LGPIPE  = 4,
  parameter int unsigned    TIMEOUT = 1023
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_cyc,
  input  logic          i_stb,
  input  logic          i_we,
  input  logic [AW-1:0] i_adr,
  input  logic [DW-1:0] i_dat,
  output logic          o_ack,
  output logic          o_stall,
  output logic          o_err,
  output logic [DW-1:0] o_data,
  output logic          o_a_cyc,
  output logic          o_a_stb,
  output logic          o_a_we,
  output logic [AW-1:0] o_a_adr,
  output logic [DW-1:0] o_a_dat,
  input  logic          i_a_ack,
  input  logic          i_a_stall,
  input  logic          i_a_err,
  input  logic [DW-1:0] i_a_data,
  output logic          o_b_cyc,
  output logic          o_b_stb,
  output logic          o_b_we,
  output logic [AW-1:0] o_b_adr,
  output logic [DW-1:0] o_b_dat,
  input  logic          i_b_ack,
  input  logic          i_b_stall,
  input  logic          i_b_err,
  input  logic [DW-1:0] i_b_data
);

  wb_slv_e           r_sel;
  logic              r_abort;
  wb_slv_e           w_dec;
  wb_slv_e           w_sel;
  logic              w_block;
  logic              w_sel_stall;
  logic              w_busy_stall;
  logic              w_accept;
  logic              w_ack;
  logic              w_err;
  logic              w_slv_err;
  logic              w_tmo;
  logic              w_a_cyc;
  logic              w_b_cyc;
  logic [LGPIPE-1:0] w_cnt;
  logic              w_full;
  logic              w_empty;

  assign w_dec = ((i_adr & B_MASK) == B_BASE) ? WB_SLV_B : WB_SLV_A;

  // With nothing outstanding the new request picks its slave immediately,
  // giving the zero-cycle request path; otherwise the owner is locked.
  assign w_sel = (w_empty && i_stb) ? w_dec : r_sel;

  assign w_block      = (!w_empty && (w_dec != r_sel)) || w_full;
  assign w_sel_stall  = (w_sel == WB_SLV_B) ? i_b_stall : i_a_stall;
  assign w_busy_stall = r_abort || w_block || w_sel_stall;

  // Internal acceptance/return terms exclude i_rst: the registers are held
  // by the asynchronous reset, only the visible outputs need gating.
  assign w_accept  = i_cyc && i_stb && !w_busy_stall;
  assign w_ack     = ((r_sel == WB_SLV_B) ? i_b_ack : i_a_ack) && !w_empty && !r_abort;
  assign w_slv_err = ((r_sel == WB_SLV_B) ? i_b_err : i_a_err) && !w_empty && !r_abort;
  assign w_err     = w_slv_err || w_tmo;

  assign w_a_cyc = i_cyc && !r_abort && (w_sel == WB_SLV_A);
  assign w_b_cyc = i_cyc && !r_abort && (w_sel == WB_SLV_B);

  assign o_a_cyc = w_a_cyc && !i_rst;
  assign o_b_cyc = w_b_cyc && !i_rst;
  assign o_a_stb = w_a_cyc && i_stb && !w_block && !i_rst;
  assign o_b_stb = w_b_cyc && i_stb && !w_block && !i_rst;

  assign o_stall = w_busy_stall || i_rst;
  assign o_ack   = w_ack && !i_rst;
  assign o_err   = w_err && !i_rst;
  assign o_data  = (r_sel == WB_SLV_B) ? i_b_data : i_a_data;

  assign o_a_we  = i_we;
  assign o_a_adr = i_adr;
  assign o_a_dat = i_dat;
  assign o_b_we  = i_we;
  assign o_b_adr = i_adr;
  assign o_b_dat = i_dat;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sel   <= WB_SLV_A;
      r_abort <= 1'b0;
    end else begin
      if (w_empty && i_stb) begin
        r_sel <= w_dec;
      end
      r_abort <= i_cyc && (r_abort || w_err);
    end
  end

  wb_pipecount #(
    .LGPIPE (LGPIPE)
  ) u_pipecount (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_inc   (w_accept),
    .i_dec   (w_ack),
    .i_clr   (!i_cyc || w_err),
    .o_cnt   (w_cnt),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

`ifdef WBS_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  logic [TMO_W-1:0] r_tmo;

  // Counts cycles since the last ack while requests are outstanding;
  // holds at TIMEOUT until the resulting abort empties the counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tmo <= '0;
    end else if (w_ack || w_empty) begin
      r_tmo <= '0;
    end else if (r_tmo != TMO_W'(TIMEOUT)) begin
      r_tmo <= r_tmo + 1'b1;
    end
  end

  assign w_tmo = (r_tmo == TMO_W'(TIMEOUT)) && !w_empty && !r_abort;
`else
  assign w_tmo = 1'b0;
`endif

  // Full count is only a debug aid here; flags carry all routing state.
  logic w_cnt_unused;
  assign w_cnt_unused = ^w_cnt;

endmodule

// File: tb/tb_wb_splitter.sv
module tb_wb_splitter;

  localparam int AW = 19;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [AW-1:0] adr = '0;
  logic [DW-1:0] dat = '0;
  logic          a_ack = 1'b0, a_stall = 1'b0, a_err = 1'b0;
  logic          b_ack = 1'b0, b_stall = 1'b0, b_err = 1'b0;
  logic [DW-1:0] a_data = '0, b_data = '0;

  logic          o_ack, o_stall, o_err;
  logic [DW-1:0] o_data;
  logic          o_a_cyc, o_a_stb, o_a_we, o_b_cyc, o_b_stb, o_b_we;
  logic [AW-1:0] o_a_adr, o_b_adr;
  logic [DW-1:0] o_a_dat, o_b_dat;

  int total = 0;
  int bad   = 0;

  wb_splitter dut (
    .i_clk(clk), .i_rst(rst),
    .i_cyc(cyc), .i_stb(stb), .i_we(we), .i_adr(adr), .i_dat(dat),
    .o_ack(o_ack), .o_stall(o_stall), .o_err(o_err), .o_data(o_data),
    .o_a_cyc(o_a_cyc), .o_a_stb(o_a_stb), .o_a_we(o_a_we),
    .o_a_adr(o_a_adr), .o_a_dat(o_a_dat),
    .i_a_ack(a_ack), .i_a_stall(a_stall), .i_a_err(a_err), .i_a_data(a_data),
    .o_b_cyc(o_b_cyc), .o_b_stb(o_b_stb), .o_b_we(o_b_we),
    .o_b_adr(o_b_adr), .o_b_dat(o_b_dat),
    .i_b_ack(b_ack), .i_b_stall(b_stall), .i_b_err(b_err), .i_b_data(b_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: outstanding count, owning slave, abort flag as plain
  // integers, stepped once per cycle from the routing rules.
  int m_cnt   = 0;
  int m_sel   = 0;
  int m_abort = 0;
  int m_quiet = 0;

  initial begin
    forever begin
      int dec_b, esel, blk, acc, own_ack, own_err, prev_cnt;
      logic e_stall, e_acyc, e_bcyc, e_astb, e_bstb, e_ack, e_err;
      logic [DW-1:0] e_data;
      @(negedge clk);
      if (rst) begin
        m_cnt = 0; m_sel = 0; m_abort = 0; m_quiet = 0;
      end
      dec_b   = ((adr & 19'h70000) == 19'h10000) ? 1 : 0;
      esel    = (m_cnt == 0 && stb) ? dec_b : m_sel;
      blk     = ((m_cnt != 0 && dec_b != m_sel) || m_cnt == 15) ? 1 : 0;
      own_ack = m_sel ? int'(b_ack) : int'(a_ack);
      own_err = m_sel ? int'(b_err) : int'(a_err);
      e_stall = rst || m_abort != 0 || blk != 0 || (esel ? b_stall : a_stall);
      e_acyc  = !rst && cyc && m_abort == 0 && esel == 0;
      e_bcyc  = !rst && cyc && m_abort == 0 && esel == 1;
      e_astb  = e_acyc && stb && blk == 0;
      e_bstb  = e_bcyc && stb && blk == 0;
      e_ack   = !rst && own_ack != 0 && m_cnt != 0 && m_abort == 0;
      e_err   = !rst && own_err != 0 && m_cnt != 0 && m_abort == 0;
`ifdef WBS_TIMEOUT_EN
      if (!rst && m_quiet == 1023 && m_cnt != 0 && m_abort == 0) e_err = 1'b1;
`endif
      e_data  = m_sel ? b_data : a_data;

      chk("m_stall", {31'd0, o_stall}, {31'd0, e_stall});
      chk("m_acyc",  {31'd0, o_a_cyc}, {31'd0, e_acyc});
      chk("m_bcyc",  {31'd0, o_b_cyc}, {31'd0, e_bcyc});
      chk("m_astb",  {31'd0, o_a_stb}, {31'd0, e_astb});
      chk("m_bstb",  {31'd0, o_b_stb}, {31'd0, e_bstb});
      chk("m_ack",   {31'd0, o_ack},   {31'd0, e_ack});
      chk("m_err",   {31'd0, o_err},   {31'd0, e_err});
      chk("m_data",  o_data, e_data);
      chk("m_bcast", {o_a_we, o_b_we, o_a_adr ^ adr, o_b_adr ^ adr}, {we, we, 19'd0, 19'd0});
      chk("m_dat",   o_a_dat ^ o_b_dat ^ dat, dat);

      if (!rst) begin
        prev_cnt = m_cnt;
        acc = (cyc && stb && !e_stall) ? 1 : 0;
        if (!cyc || e_err) m_cnt = 0;
        else m_cnt = m_cnt + acc - (e_ack ? 1 : 0);
        if (e_ack || prev_cnt == 0) m_quiet = 0;
        else if (m_quiet != 1023) m_quiet++;
        if (prev_cnt == 0 && stb) m_sel = dec_b;
        m_abort = (cyc && (m_abort != 0 || e_err)) ? 1 : 0;
      end
    end
  end

  initial begin
    int acks, bcyc, stalls, first_b, accepted, pend, errs, first_err;
    logic acc;

    // Reset values
    @(negedge clk);
    chk("rst_stall", {31'd0, o_stall}, 32'd1);
    chk("rst_ack",   {31'd0, o_ack},   32'd0);
    chk("rst_cyc",   {30'd0, o_a_cyc, o_b_cyc}, 32'd0);
    tick();
    rst = 1'b0;

    // Three back-to-back reads to A, 1-cycle ack latency
    cyc = 1'b1; adr = 19'h00010;
    acks = 0; bcyc = 0;
    for (int i = 0; i < 5; i++) begin
      stb = (i < 3); a_ack = (i >= 1 && i <= 3);
      a_data = 32'hAA00_0000 + i;
      @(negedge clk);
      if (o_ack) acks++;
      if (o_b_cyc) bcyc++;
      if (i == 0) chk("t1_astb", {31'd0, o_a_stb}, 32'd1);
      if (i == 1) chk("t1_data", o_data, 32'hAA00_0001);
      tick();
    end
    chk("t1_acks", acks, 3);
    chk("t1_bcyc", bcyc, 0);
    stb = 1'b1; adr = 19'h10004;
    @(negedge clk);
    chk("t1_empty_to_b", {31'd0, o_b_stb}, 32'd1);
    tick();
    cyc = 1'b0; stb = 1'b0;
    tick();

    // Read A then B with A ack delayed: switch penalty
    cyc = 1'b1; stb = 1'b1; adr = 19'h00010;
    tick();
    adr = 19'h10004; stalls = 0; first_b = -1;
    for (int i = 0; i < 7; i++) begin
      a_ack = (i == 4); stb = (i <= 5); b_ack = (i == 6);
      @(negedge clk);
      if (i <= 4 && o_stall) stalls++;
      if (o_b_stb && first_b < 0) first_b = i;
      tick();
    end
    chk("t2_stall_cycles", stalls, 5);
    chk("t2_bstb_cycle", first_b, 5);
    a_ack = 1'b0; b_ack = 1'b0; cyc = 1'b0; stb = 1'b0;
    tick();

    // Burst of 4 to A with slave stall
    cyc = 1'b1; adr = 19'h00020; accepted = 0; pend = 0; acks = 0;
    for (int i = 0; i < 16; i++) begin
      stb = (accepted < 4); a_stall = (i >= 1 && i <= 3); a_ack = (pend != 0);
      @(negedge clk);
      acc = o_a_stb && !o_stall;
      if (acc) accepted++;
      if (o_ack) acks++;
      pend = acc ? 1 : 0;
      tick();
    end
    chk("t3_accepted", accepted, 4);
    chk("t3_acks", acks, 4);
    a_stall = 1'b0; a_ack = 1'b0; cyc = 1'b0; stb = 1'b0;
    tick();

    // Slave B error with two outstanding
    cyc = 1'b1; stb = 1'b1; adr = 19'h10008;
    tick(); tick();
    stb = 1'b0; b_err = 1'b1;
    @(negedge clk);
    chk("t4_err", {31'd0, o_err}, 32'd1);
    tick();
    b_err = 1'b0; b_ack = 1'b1;
    @(negedge clk);
    chk("t4_cyc_low", {30'd0, o_a_cyc, o_b_cyc}, 32'd0);
    chk("t4_ack_dropped", {31'd0, o_ack}, 32'd0);
    tick();
    b_ack = 1'b0; cyc = 1'b0;
    tick();
    cyc = 1'b1; stb = 1'b1; adr = 19'h00010;
    @(negedge clk);
    chk("t4_new_astb", {31'd0, o_a_stb}, 32'd1);
    tick();
    stb = 1'b0; a_ack = 1'b1;
    tick();
    a_ack = 1'b0; cyc = 1'b0;
    tick();

    // Fill 15 outstanding, then free a slot; reset mid-burst
    cyc = 1'b1; stb = 1'b1; adr = 19'h00010;
    repeat (15) tick();
    @(negedge clk);
    chk("t5_full_stall", {31'd0, o_stall}, 32'd1);
    tick();
    a_ack = 1'b1;
    @(negedge clk);
    chk("t5_ack_when_full", {31'd0, o_ack}, 32'd1);
    chk("t5_still_full", {31'd0, o_stall}, 32'd1);
    tick();
    a_ack = 1'b0;
    @(negedge clk);
    chk("t5_slot_free", {31'd0, o_stall}, 32'd0);
    tick();
    rst = 1'b1; a_ack = 1'b1; a_err = 1'b1;
    #1;
    chk("t5_rst_stall", {31'd0, o_stall}, 32'd1);
    chk("t5_rst_ack_err", {30'd0, o_ack, o_err}, 32'd0);
    chk("t5_rst_cyc_stb", {28'd0, o_a_cyc, o_a_stb, o_b_cyc, o_b_stb}, 32'd0);
    tick();
    a_ack = 1'b0; a_err = 1'b0; cyc = 1'b0; stb = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Single unacked read to A
    cyc = 1'b1; stb = 1'b1; adr = 19'h00010;
    tick();
    stb = 1'b0; errs = 0; first_err = -1;
    for (int j = 0; j < 2000; j++) begin
      @(negedge clk);
      if (o_err) begin
        errs++;
        if (first_err < 0) first_err = j;
      end
      tick();
    end
`ifdef WBS_TIMEOUT_EN
    chk("t6_tmo_errs", errs, 1);
    chk("t6_tmo_cycle", first_err, 1023);
`else
    chk("t6_no_err", errs, 0);
`endif
    cyc = 1'b0;
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      if (rst) rst = ($urandom_range(0, 1) == 0);
      else rst = ($urandom_range(0, 599) == 0);
      if (cyc) cyc = ($urandom_range(0, 39) != 0);
      else cyc = ($urandom_range(0, 3) == 0);
      stb = cyc && ($urandom_range(0, 2) != 0);
      adr = {($urandom_range(0, 2) == 0) ? 3'b001 : 3'($urandom), 16'($urandom)};
      we = 1'($urandom); dat = $urandom;
      a_ack = ($urandom_range(0, 2) == 0); a_stall = ($urandom_range(0, 3) == 0);
      a_err = ($urandom_range(0, 59) == 0); a_data = $urandom;
      b_ack = ($urandom_range(0, 2) == 0); b_stall = ($urandom_range(0, 3) == 0);
      b_err = ($urandom_range(0, 59) == 0); b_data = $urandom;
      tick();
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
